// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit, request-to-send, 11-bit shift,
// line-ACK check and device response wait with one-shot resend handling.
module ps2_host_cmd_ctrl #(
  parameter int unsigned INHIBIT_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned MAX_RETRY      = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_ready,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_inhibit,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 2);
  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SEND, S_WAIT_ACK, S_WAIT_IDLE, S_WAIT_RESP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
  logic             w_fall, w_timeout;
  logic [7:0]       r_byte, w_byte_nxt;
  logic             r_par, w_par_nxt;
  logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic [RTY_W-1:0] r_retry, w_retry_nxt;
  logic [1:0]       r_err_code, w_err_code_nxt;
  logic             w_done_evt, w_err_evt;
  logic             r_cmd_ready, r_clk_oe, r_data_oe, r_rx_inhibit, r_busy, r_done, r_err;
  logic             w_cmd_ready_nxt, w_clk_oe_nxt, w_data_oe_nxt, w_rx_inhibit_nxt, w_busy_nxt;

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (r_tmr == TO_LAST);

  // Line synchronisers preset high so reset never fabricates a falling edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1; r_clk_prev <= 1'b1;
      r_dat_s1 <= 1'b1; r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk_in;  r_clk_s2 <= r_clk_s1; r_clk_prev <= r_clk_s2;
      r_dat_s1 <= i_ps2_data_in; r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and datapath updates; timeout takes priority over any line event.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_nxt     = r_byte;
    w_par_nxt      = r_par;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_tmr_nxt      = r_tmr + TMR_W'(1);
    w_retry_nxt    = r_retry;
    w_err_code_nxt = r_err_code;
    w_done_evt     = 1'b0;
    w_err_evt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmr_nxt = '0;
        if (i_cmd_valid && r_cmd_ready) begin
          w_byte_nxt     = i_cmd_data;
          w_par_nxt      = ~^i_cmd_data;
          w_err_code_nxt = 2'd0;
          w_retry_nxt    = '0;
          w_bit_cnt_nxt  = 4'd0;
          w_state_nxt    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_tmr == INH_LAST) begin
          w_tmr_nxt     = '0;
          w_bit_cnt_nxt = 4'd0;
          w_state_nxt   = S_SEND;
        end
      end
      S_SEND, S_WAIT_ACK, S_WAIT_IDLE, S_WAIT_RESP: begin
        if (w_timeout) begin
          w_err_evt      = 1'b1;
          w_err_code_nxt = 2'd1;
          w_state_nxt    = S_IDLE;
        end else if (r_state == S_SEND) begin
          if (w_fall) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd9) w_state_nxt = S_WAIT_ACK;
          end
        end else if (r_state == S_WAIT_ACK) begin
          if (w_fall) begin
            if (!r_dat_s2) begin
              w_state_nxt = S_WAIT_IDLE;
            end else begin
              w_err_evt      = 1'b1;
              w_err_code_nxt = 2'd2;
              w_state_nxt    = S_IDLE;
            end
          end
        end else if (r_state == S_WAIT_IDLE) begin
          if (r_clk_s2 && r_dat_s2) begin
            w_tmr_nxt   = '0;
            w_state_nxt = S_WAIT_RESP;
          end
        end else if (i_rx_valid) begin
          if (i_rx_data == 8'hFA) begin
            w_done_evt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (i_rx_data == 8'hFE) begin
            if (r_retry < RTY_MAX) begin
              w_retry_nxt   = r_retry + RTY_W'(1);
              w_tmr_nxt     = '0;
              w_bit_cnt_nxt = 4'd0;
              w_state_nxt   = S_INHIBIT;
            end else begin
              w_err_evt      = 1'b1;
              w_err_code_nxt = 2'd3;
              w_state_nxt    = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values for the upcoming state; registered below.
  always_comb begin
    w_clk_oe_nxt     = (w_state_nxt == S_INHIBIT);
    w_data_oe_nxt    = 1'b0;
    w_rx_inhibit_nxt = (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_SEND) ||
                       (w_state_nxt == S_WAIT_ACK) || (w_state_nxt == S_WAIT_IDLE);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_cmd_ready_nxt  = (w_state_nxt == S_IDLE);
    if (w_state_nxt == S_SEND) begin
      if (w_bit_cnt_nxt == 4'd0)      w_data_oe_nxt = 1'b1;
      else if (w_bit_cnt_nxt <= 4'd8) w_data_oe_nxt = ~w_byte_nxt[3'(w_bit_cnt_nxt - 4'd1)];
      else if (w_bit_cnt_nxt == 4'd9) w_data_oe_nxt = ~w_par_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte <= '0; r_par <= 1'b0; r_bit_cnt <= '0; r_tmr <= '0; r_retry <= '0;
      r_err_code <= '0; r_cmd_ready <= 1'b1; r_clk_oe <= 1'b0; r_data_oe <= 1'b0;
      r_rx_inhibit <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_byte <= w_byte_nxt; r_par <= w_par_nxt; r_bit_cnt <= w_bit_cnt_nxt;
      r_tmr <= w_tmr_nxt; r_retry <= w_retry_nxt; r_err_code <= w_err_code_nxt;
      r_cmd_ready <= w_cmd_ready_nxt; r_clk_oe <= w_clk_oe_nxt; r_data_oe <= w_data_oe_nxt;
      r_rx_inhibit <= w_rx_inhibit_nxt; r_busy <= w_busy_nxt;
      r_done <= w_done_evt; r_err <= w_err_evt;
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;
  assign o_rx_inhibit  = r_rx_inhibit;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: open-drain device model with a byte scoreboard
// checking each transmitted frame, plus pulse monitors for done/err.
module tb_ps2_host_cmd_ctrl;

  localparam int INH  = 100;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       cmd_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, busy, done, err;
  logic [1:0] err_code;
  wire        line_clk  = dev_clk & ~ps2_clk_oe;
  wire        line_data = dev_data & ~ps2_data_oe;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic err_lines = 1'b0;
  logic [7:0] exp_q[$];

  ps2_host_cmd_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .MAX_RETRY(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd_data(cmd_data),
    .o_cmd_ready(cmd_ready), .i_ps2_clk_in(line_clk), .i_ps2_data_in(line_data),
    .o_ps2_clk_oe(ps2_clk_oe), .o_ps2_data_oe(ps2_data_oe), .i_rx_valid(rx_valid),
    .i_rx_data(rx_data), .o_rx_inhibit(rx_inhibit), .o_busy(busy), .o_done(done),
    .o_err(err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt   <= err_cnt + 1;
      err_lines <= ps2_clk_oe | ps2_data_oe;
    end
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick;
    rx_valid = 1'b0;
  endtask

  // Device side: wait for RTS, clock npulses, sample on each rising edge.
  task automatic dev_frame(input int npulses, input bit ack, input int inject_at,
                           output logic [9:0] smp, output bit ok);
    int n;
    ok = 1'b1; smp = '1; n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < INH + 100) begin tick; n++; end
    if (!(ps2_data_oe && !ps2_clk_oe)) begin ok = 1'b0; return; end
    repeat (HALF) tick;
    for (int k = 1; k <= npulses; k++) begin
      if (k == 11) dev_data = ack;
      dev_clk = 1'b0;
      for (int j = 0; j < HALF; j++) begin
        cmd_valid = (k == inject_at) && (j == 0);
        if (cmd_valid) cmd_data = 8'h55;
        tick;
      end
      cmd_valid = 1'b0;
      dev_clk = 1'b1;
      if (k <= 10) smp[k-1] = line_data;
      repeat (HALF) tick;
    end
    dev_data = 1'b1;
  endtask

  task automatic frame_and_score(input bit ack, input int inject_at, input string nm);
    logic [9:0] smp;
    logic [7:0] e;
    bit ok;
    dev_frame(11, ack, inject_at, smp, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL %s_rts: no request-to-send seen, got 0 required 1", nm);
    end else if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s_sb: frame %h seen but scoreboard empty", nm, smp);
    end else begin
      e = exp_q.pop_front();
      if (smp !== {1'b1, ~^e, e}) begin
        n_fail++; $display("FAIL %s_frame: got %h required %h", nm, smp, {1'b1, ~^e, e});
      end
    end
  endtask

  task automatic wait_resp(input string nm);
    int n;
    n = 0;
    while (!(busy && !rx_inhibit) && n < 200) begin tick; n++; end
    n_checks++;
    if (!(busy && !rx_inhibit)) begin
      n_fail++; $display("FAIL %s_wait_resp: rx_inhibit=%b busy=%b required 0/1", nm, rx_inhibit, busy);
    end
  endtask

  task automatic wait_err(input int base, input string nm);
    int n;
    n = 0;
    while (err_cnt == base && n < 200) begin tick; n++; end
    n_checks++;
    if (err_cnt != base + 1) begin
      n_fail++; $display("FAIL %s_err_pulse: count %0d required %0d", nm, err_cnt - base, 1);
    end
  endtask

  task automatic test_reset;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    n_checks++;
    if ({cmd_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, busy, done, err, err_code} !== 9'b1_0000_0000) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b",
               {cmd_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, busy, done, err, err_code}, 9'b1_0000_0000);
    end
  endtask

  task automatic test_basic;
    int cnt, d0;
    d0 = done_cnt;
    exp_q.push_back(8'hED);
    send_cmd(8'hED);
    cnt = 0;
    while (ps2_clk_oe && cnt < INH + 50) begin cnt++; tick; end
    n_checks++;
    if (cnt !== INH) begin n_fail++; $display("FAIL inhibit_len: got %0d required %0d", cnt, INH); end
    frame_and_score(1'b0, 0, "basic");
    wait_resp("basic");
    rx_pulse(8'hFA);
    n_checks++;
    if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL basic_done: got %b required 10", {done, err}); end
    tick;
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done_once: got %0d required 1", done_cnt - d0); end
    n_checks++;
    if ({cmd_ready, busy, err_code} !== 4'b1000) begin
      n_fail++; $display("FAIL basic_idle: got %b required 1000", {cmd_ready, busy, err_code});
    end
  endtask

  task automatic test_nack;
    int e0;
    e0 = err_cnt;
    exp_q.push_back(8'hA5);
    send_cmd(8'hA5);
    frame_and_score(1'b1, 0, "nack");
    wait_err(e0, "nack");
    n_checks++;
    if ({err_code, err_lines, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL nack_code: got %b required 1000", {err_code, err_lines, busy});
    end
  endtask

  task automatic test_timeout;
    int n;
    send_cmd(8'h12);
    n = 0;
    while (!ps2_data_oe && n < INH + 10) begin tick; n++; end
    n = 0;
    while (!err && n < TO + 10) begin tick; n++; end
    n_checks++;
    if (n !== TO) begin n_fail++; $display("FAIL timeout_len: got %0d required %0d", n, TO); end
    n_checks++;
    if ({err_code, ps2_clk_oe, ps2_data_oe} !== 4'b0100) begin
      n_fail++; $display("FAIL timeout_code: got %b required 0100", {err_code, ps2_clk_oe, ps2_data_oe});
    end
    tick;
  endtask

  task automatic test_retry;
    int d0, e0;
    d0 = done_cnt;
    exp_q.push_back(8'hF3); exp_q.push_back(8'hF3);
    send_cmd(8'hF3);
    frame_and_score(1'b0, 0, "retry1");
    wait_resp("retry1");
    rx_pulse(8'hFE);
    frame_and_score(1'b0, 0, "retry2");
    wait_resp("retry2");
    rx_pulse(8'hFA);
    tick;
    n_checks++;
    if (done_cnt - d0 !== 1 || err_code !== 2'd0) begin
      n_fail++; $display("FAIL retry_done: got %0d/%0d required 1/0", done_cnt - d0, err_code);
    end
    e0 = err_cnt;
    exp_q.push_back(8'hF4); exp_q.push_back(8'hF4);
    send_cmd(8'hF4);
    frame_and_score(1'b0, 0, "exh1");
    wait_resp("exh1");
    rx_pulse(8'hFE);
    frame_and_score(1'b0, 0, "exh2");
    wait_resp("exh2");
    rx_pulse(8'hFE);
    wait_err(e0, "exhaust");
    n_checks++;
    if (err_code !== 2'd3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL exhaust_code: got %0d busy %b required 3 busy 0", err_code, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] smp;
    bit ok;
    int d0;
    send_cmd(8'h3C);
    dev_frame(4, 1'b0, 0, smp, ok);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, cmd_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_mid: got %b required 0001", {ps2_clk_oe, ps2_data_oe, busy, cmd_ready});
    end
    d0 = done_cnt;
    exp_q.push_back(8'hFF);
    send_cmd(8'hFF);
    frame_and_score(1'b0, 0, "after_rst");
    wait_resp("after_rst");
    rx_pulse(8'hFA);
    tick;
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL after_rst_done: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_ignore;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(8'h81);
    send_cmd(8'h81);
    frame_and_score(1'b0, 3, "ignore");
    wait_resp("ignore");
    rx_pulse(8'h1C);
    repeat (5) tick;
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ignore_rx: done %0d busy %b required 0 1", done_cnt - d0, busy);
    end
    rx_pulse(8'hFA);
    tick;
    n_checks++;
    if (done_cnt - d0 !== 1 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL ignore_done: got %0d/%b required 1/1", done_cnt - d0, cmd_ready);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_empty: got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_nack;
    test_timeout;
    test_retry;
    test_reset_mid;
    test_ignore;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_cmd_ctrl.md
Name: ps2_host_cmd_ctrl

Overview:
- Host-to-device command sequencer for the PS/2 port of the 68k PS/2 decoder chip.
- Accepts one command byte from the bus side (e.g. 0xED set-LEDs, 0xFF reset) and drives the open-drain PS/2 clock/data lines through the inhibit, request-to-send, 11-bit shift and line-ACK sequence.
- Then waits for the device response byte (0xFA ack / 0xFE resend) from the existing receive decoder.
- While transmitting, masks the decoder so it does not parse the host's own frame.

Parameters:
INHIBIT_CYCLES, 1000, clk cycles clock is held low before RTS (100 us at 10 MHz)
TIMEOUT_CYCLES, 200000, max clk cycles per phase (RTS-to-ACK, and response wait)
MAX_RETRY, 1, retransmissions allowed on 0xFE before error

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command byte offered
cmd_data  in  8  command byte
cmd_ready  out  1  high only in IDLE
ps2_clk_in  in  1  raw PS/2 clock pin (asynchronous)
ps2_data_in  in  1  raw PS/2 data pin (asynchronous)
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_data_oe  out  1  1 = pull PS/2 data low
rx_valid  in  1  one-cycle strobe from receive decoder
rx_data  in  8  received byte
rx_inhibit  out  1  1 = decoder must ignore line activity
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on 0xFA received
err  out  1  one-cycle pulse on failure
err_code  out  2  0 none, 1 timeout, 2 no line ACK, 3 resend exhausted; held until next command accepted

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1. Sync flops preset to 1 so no false edge. Reset mid-operation releases both lines on the same edge.
- ps2_clk_in and ps2_data_in pass through 2-FF synchronisers. fall = prev_sync & ~sync. All line decisions use synced values.
- Handshake: byte accepted when cmd_valid & cmd_ready on a rising clk edge.
  - Latches cmd_data, computes odd parity p = ~^cmd_data, clears err_code, retry count and bit count.
  - Enters INHIBIT. cmd_valid is ignored while busy.
- INHIBIT: clk_oe=1, data_oe=0, rx_inhibit=1. After exactly INHIBIT_CYCLES cycles go to RTS.
- RTS/SEND:
  - data_oe=1 (start bit 0), clk_oe=0; timeout counter restarts.
  - Falling edges 1..8: data_oe = ~byte[n-1] (LSB first).
  - Falling edge 9: data_oe = ~p.
  - Falling edge 10: data_oe=0 (stop bit). Go to WAIT_ACK.
- WAIT_ACK: on falling edge 11, sample synced data.
  - 0: go to WAIT_IDLE.
  - 1: err pulse, err_code=2, go to IDLE.
- WAIT_IDLE: wait for synced clock=1 and data=1, then go to WAIT_RESP with rx_inhibit=0 and timeout counter restarted.
- Timeout: counter runs in RTS, SEND, WAIT_ACK and WAIT_IDLE combined, and separately in WAIT_RESP. Reaching TIMEOUT_CYCLES gives err pulse, err_code=1, both oe=0, IDLE.
- WAIT_RESP: on rx_valid:
  - 0xFA: done pulse, IDLE.
  - 0xFE with retry<MAX_RETRY: retry++, back to INHIBIT with the same byte.
  - 0xFE with retry=MAX_RETRY: err pulse, err_code=3, IDLE.
  - Any other byte: ignored, timer keeps running.
- rx_inhibit=1 from INHIBIT through WAIT_IDLE; 0 in IDLE and WAIT_RESP.
- done and err never both high. ps2_clk_oe and ps2_data_oe are registered outputs with no combinational path from inputs.
- If a falling edge and a timeout coincide, the timeout wins.

Test Plan:
- 0xED, device model clocks at 10 kHz, line-ACK 0, then returns 0xFA:
  - clk_oe low for 1000 cycles.
  - Device samples data bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; err_code=0; cmd_ready returns to 1.
- Device drives ACK bit 1 on edge 11 -> err pulse, err_code=2, both oe=0 next cycle.
- Device never clocks after RTS -> err at TIMEOUT_CYCLES after RTS entry, err_code=1, lines released.
- Response 0xFE then 0xFA -> second complete frame of the same byte, then done. Response 0xFE, 0xFE (MAX_RETRY=1) -> err_code=3.
- rst asserted after edge 4 of SEND -> next cycle clk_oe=data_oe=0, busy=0, cmd_ready=1. A new 0xFF then completes normally.
- cmd_valid with 0x55 during SEND is ignored, and only the original byte is transmitted. rx_valid 0x1C during WAIT_RESP is ignored; a later 0xFA gives done.
